// File: rtl/bcd_counter_999.sv
// bcd_counter_999: three-digit cascaded BCD counter (000-999) with an internal
// prescaler and a start/stop/pause FSM. Feeds the per-digit 7-segment decoders.
// Optional macro BCD_CNT_DOWN_EN adds an up_dn input (1 = up, 0 = down).
module bcd_counter_999 #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 10,
    parameter int WRAP    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef BCD_CNT_DOWN_EN
    input  logic       up_dn,
`endif
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_hundreds,
    output logic       running,
    output logic       tc_pulse
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("bcd_counter_999: CLK_HZ/TICK_HZ must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
    logic          ss_q;
    logic          running_q, running_d;
    logic          tc_q, tc_d;

    logic rise, tick, up, at_term;

    // Next-state logic: edge detect, prescaler, digit cascade, FSM, clear override
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        tc_d    = 1'b0;

        rise = start_stop & ~ss_q;
        tick = (state_q == RUN) && (presc_q == PW'(DIV - 1));
`ifdef BCD_CNT_DOWN_EN
        up = up_dn;
`else
        up = 1'b1;
`endif
        // Terminal value depends on direction: 999 going up, 000 going down
        at_term = up ? (ones_q == 4'd9 && tens_q == 4'd9 && hund_q == 4'd9)
                     : (ones_q == 4'd0 && tens_q == 4'd0 && hund_q == 4'd0);

        // Prescaler only advances in RUN, is frozen in PAUSE, parked at 0 otherwise
        case (state_q)
            RUN:     presc_d = tick ? '0 : presc_q + 1'b1;
            PAUSE:   presc_d = presc_q;
            default: presc_d = '0;
        endcase

        // Digit update on tick; carry/borrow ripple naturally wraps 999<->000
        if (tick) begin
            tc_d = at_term;
            if (!(at_term && WRAP == 0)) begin
                if (up) begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        if (tens_q == 4'd9) begin
                            tens_d = 4'd0;
                            hund_d = (hund_q == 4'd9) ? 4'd0 : hund_q + 4'd1;
                        end else begin
                            tens_d = tens_q + 4'd1;
                        end
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        if (tens_q == 4'd0) begin
                            tens_d = 4'd9;
                            hund_d = (hund_q == 4'd0) ? 4'd9 : hund_q - 4'd1;
                        end else begin
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
        end

        // FSM; saturating terminal tick beats a coincident rise
        case (state_q)
            IDLE:    if (rise) state_d = RUN;
            RUN: begin
                if (tick && at_term && WRAP == 0) state_d = DONE;
                else if (rise)                    state_d = PAUSE;
            end
            PAUSE:   if (rise) state_d = RUN;
            default: state_d = DONE;
        endcase

        // clear dominates rise and tick
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            hund_d  = 4'd0;
            tc_d    = 1'b0;
        end

        running_d = (state_d == RUN);
    end

    // State registers; edge-detect flop resets high so a held button cannot start the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            hund_q    <= 4'd0;
            ss_q      <= 1'b1;
            running_q <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
            ss_q      <= start_stop;
            running_q <= running_d;
            tc_q      <= tc_d;
        end
    end

    assign bcd_ones     = ones_q;
    assign bcd_tens     = tens_q;
    assign bcd_hundreds = hund_q;
    assign running      = running_q;
    assign tc_pulse     = tc_q;

endmodule
